// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the
// set of opcodes that run on the iterative datapath.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_ASR = 4'd9,
        OP_MUL = 4'd10,
        OP_PAR = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // One bit per opcode; set for SHL, SHR, ASR and MUL.
    localparam logic [15:0] ITER_OPS = 16'b0000_0111_1000_0000;

    function automatic logic is_iter_op(input alu_op_e op);
        return ITER_OPS[op];
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Bit-serial datapath for shifts and shift-add multiply. Exposes the
// value the final step produces so the owner can capture it on that edge.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [SAW-1:0] amt,
    output logic           last,
    output logic [W-1:0]   result,
    output logic           carry
);
    localparam int CW = $clog2(W + 1);

    alu_op_e       mode;
    logic [W-1:0]  mcand;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [CW-1:0] cnt;

    logic [W:0]    sum;
    logic [W-1:0]  hi_nxt;
    logic [W-1:0]  lo_nxt;
    logic          cy_nxt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        hi_nxt = hi;
        lo_nxt = lo;
        cy_nxt = 1'b0;
        case (mode)
            OP_SHL: begin
                lo_nxt = {lo[W-2:0], 1'b0};
                cy_nxt = lo[W-1];
            end
            OP_SHR: begin
                lo_nxt = {1'b0, lo[W-1:1]};
                cy_nxt = lo[0];
            end
            OP_ASR: begin
                lo_nxt = {lo[W-1], lo[W-1:1]};
                cy_nxt = lo[0];
            end
            OP_MUL: begin
                // Multiplier drains out of lo while product bits shift in from hi.
                hi_nxt = sum[W:1];
                lo_nxt = {sum[0], lo[W-1:1]};
                cy_nxt = |sum[W:1];
            end
            default: ;
        endcase
    end

    assign last   = (cnt == CW'(1));
    assign result = lo_nxt;
    assign carry  = cy_nxt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode  <= OP_ADD;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (load) begin
            mode  <= op;
            mcand <= a;
            hi    <= '0;
            lo    <= (op == OP_MUL) ? b : a;
            cnt   <= (op == OP_MUL) ? CW'(W) : CW'(amt);
        end else if (step && (cnt != '0)) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: valid/ready handshake, single-cycle ops, result and
// flag registers; shifts and multiply run on seq_alu_iter.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4,
    parameter int SAW = $clog2(W)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    output logic           InReady,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [OPW-1:0] OP,
    output logic           OutValid,
    input  logic           OutReady,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd,
    output logic           Carry,
    output logic           Illegal
);
    alu_state_e     state;
    logic [W-1:0]   out_q;
    logic           carry_q;
    logic           illegal_q;

    alu_op_e        op;
    logic [SAW-1:0] amt;
    logic           accept;
    logic           goes_iter;

    logic [W:0]     sum;
    logic [W-1:0]   res;
    logic           res_carry;
    logic           res_illegal;

    logic           iter_last;
    logic [W-1:0]   iter_result;
    logic           iter_carry;

    assign op        = alu_op_e'(OP);
    assign amt       = InputB[SAW-1:0];
    assign InReady   = (state == IDLE) || ((state == DONE) && OutReady);
    assign accept    = InValid && InReady;
    // A shift by zero completes in one cycle and returns InputA.
    assign goes_iter = is_iter_op(op) && ((op == OP_MUL) || (amt != '0));

    always_comb begin
        sum         = {1'b0, InputA} + {1'b0, InputB}
                    + {{W{1'b0}}, (op == OP_ADC) && carry_q};
        res         = '0;
        res_carry   = carry_q;
        res_illegal = 1'b0;
        case (op)
            OP_ADD, OP_ADC: {res_carry, res} = sum;
            OP_SUB: begin
                res       = InputA - InputB;
                res_carry = (InputA >= InputB);
            end
            OP_AND:                 res = InputA & InputB;
            OP_OR:                  res = InputA | InputB;
            OP_XOR:                 res = InputA ^ InputB;
            OP_MOV:                 res = InputB;
            OP_SHL, OP_SHR, OP_ASR: res = InputA;
            OP_PAR:                 res = {{(W-1){1'b0}}, ^InputB};
            default:                res_illegal = 1'b1;
        endcase
    end

    seq_alu_iter #(.W(W), .SAW(SAW)) u_iter (
        .clk    (Clk),
        .rst    (Reset),
        .load   (accept && goes_iter),
        .step   (state == ITER),
        .op     (op),
        .a      (InputA),
        .b      (InputB),
        .amt    (amt),
        .last   (iter_last),
        .result (iter_result),
        .carry  (iter_carry)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            out_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            if (goes_iter) begin
                state <= ITER;
            end else begin
                state     <= DONE;
                out_q     <= res;
                carry_q   <= res_carry;
                illegal_q <= res_illegal;
            end
        end else if ((state == ITER) && iter_last) begin
            state     <= DONE;
            out_q     <= iter_result;
            carry_q   <= iter_carry;
            illegal_q <= 1'b0;
        end else if ((state == DONE) && OutReady) begin
            state <= IDLE;
        end
    end

    assign OutValid = (state == DONE);
    assign Out      = out_q;
    assign Carry    = carry_q;
    assign Illegal  = illegal_q;
    assign Zero     = ~|out_q;
    assign Parity   = ^out_q;
    assign Odd      = out_q[0];

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=8): directed cases plus random
// operations checked against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic [3:0]   OP;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] Out;
    logic         Zero;
    logic         Parity;
    logic         Odd;
    logic         Carry;
    logic         Illegal;

    int           total = 0;
    int           bad   = 0;
    logic         carry_m = 1'b0;
    logic [W-1:0] exp_out;
    logic         exp_c;
    logic         exp_ill;
    int           exp_lat;

    always #5 Clk = ~Clk;

    seq_alu #(.W(W), .OPW(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InputA   (InputA),
        .InputB   (InputB),
        .OP       (OP),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Out      (Out),
        .Zero     (Zero),
        .Parity   (Parity),
        .Odd      (Odd),
        .Carry    (Carry),
        .Illegal  (Illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the opcode rules.
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, output logic [7:0] r, output logic c,
                                  output logic ill, output int lat);
        int n;
        int s;
        n   = int'(b[2:0]);
        r   = '0;
        c   = cin;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: begin s = int'(a) + int'(b); r = s[7:0]; c = s[8]; end
            4'd1: begin s = int'(a) + int'(b) + int'(cin); r = s[7:0]; c = s[8]; end
            4'd2: begin r = a - b; c = (a >= b); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = b;
            4'd7: begin r = a << n; if (n > 0) c = a[8-n]; lat = 1 + n; end
            4'd8: begin r = a >> n; if (n > 0) c = a[n-1]; lat = 1 + n; end
            4'd9: begin r = 8'($signed(a) >>> n); if (n > 0) c = a[n-1]; lat = 1 + n; end
            4'd10: begin s = int'(a) * int'(b); r = s[7:0]; c = |s[15:8]; lat = 1 + W; end
            4'd11: r = {7'b0, ^b};
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic check_result(input string tag);
        check({tag, "_out"},     32'(Out),     32'(exp_out));
        check({tag, "_carry"},   32'(Carry),   32'(exp_c));
        check({tag, "_illegal"}, 32'(Illegal), 32'(exp_ill));
        check({tag, "_zero"},    32'(Zero),    32'(exp_out == 8'h00));
        check({tag, "_parity"},  32'(Parity),  32'(^exp_out));
        check({tag, "_odd"},     32'(Odd),     32'(exp_out[0]));
    endtask

    // Issue one op, wait for its result and check latency, value and flags.
    task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int g;
        int lat;
        model(op, a, b, carry_m, exp_out, exp_c, exp_ill, exp_lat);
        carry_m = exp_c;
        @(negedge Clk);
        g = 0;
        while (!InReady && g < 50) begin
            @(negedge Clk);
            g++;
        end
        check({tag, "_in_ready"}, 32'(InReady), 32'd1);
        OP = op; InputA = a; InputB = b; InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        InputA  = 8'($urandom);
        InputB  = 8'($urandom);
        OP      = 4'($urandom);
        lat = 1;
        while (!OutValid && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_result(tag);
    endtask

    task automatic release_out();
        @(negedge Clk);
        OutReady = 1'b1;
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        check("release_valid", 32'(OutValid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        issue(tag, op, a, b);
        release_out();
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        InputA = '0; InputB = '0; OP = '0;
        repeat (2) @(posedge Clk);
        #1;
        exp_out = '0; exp_c = 1'b0; exp_ill = 1'b0;
        check("rst_valid", 32'(OutValid), 32'd0);
        check_result("rst");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_in_ready", 32'(InReady), 32'd1);

        // Carry chain
        run_op("add", 4'd0, 8'hF0, 8'h20);
        run_op("adc", 4'd1, 8'h01, 8'h01);
        // Multiply
        run_op("mul1", 4'd10, 8'h13, 8'h0E);
        run_op("mul2", 4'd10, 8'h80, 8'h02);
        // Shifts
        run_op("asr3", 4'd9, 8'h90, 8'h03);
        run_op("shl0", 4'd7, 8'h81, 8'h00);

        // Backpressure, then back-to-back issue with no bubble
        issue("sub", 4'd2, 8'h05, 8'h07);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            check("bp_out",      32'(Out),      32'h0FE);
            check("bp_carry",    32'(Carry),    32'd0);
            check("bp_in_ready", 32'(InReady),  32'd0);
            check("bp_valid",    32'(OutValid), 32'd1);
        end
        @(negedge Clk);
        model(4'd5, 8'hFF, 8'h0F, carry_m, exp_out, exp_c, exp_ill, exp_lat);
        carry_m = exp_c;
        OutReady = 1'b1; OP = 4'd5; InputA = 8'hFF; InputB = 8'h0F; InValid = 1'b1;
        #1;
        check("b2b_in_ready", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0; OutReady = 1'b0;
        check("b2b_valid", 32'(OutValid), 32'd1);
        check_result("b2b");
        release_out();

        // Reset in the middle of a multiply, with Carry set beforehand
        run_op("add_pre", 4'd0, 8'hF0, 8'h20);
        @(negedge Clk);
        OP = 4'd10; InputA = 8'h37; InputB = 8'h5B; InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        repeat (3) @(posedge Clk);
        #3;
        check("mid_valid_pre", 32'(OutValid), 32'd0);
        Reset = 1'b1;
        #1;
        carry_m = 1'b0;
        check("mid_rst_valid", 32'(OutValid), 32'd0);
        check("mid_rst_out",   32'(Out),      32'd0);
        check("mid_rst_carry", 32'(Carry),    32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_op("par", 4'd11, 8'hA5, 8'h07);

        // Illegal opcode leaves Carry alone; next legal result clears Illegal
        run_op("sub_pre", 4'd2, 8'h07, 8'h05);
        run_op("illegal", 4'd13, 8'h12, 8'h34);
        run_op("mov", 4'd6, 8'h00, 8'h5A);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            run_op("rnd", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
